// File: rtl/halt_sequencer_pkg.sv
// Shared encodings for the halt sequencer: panel mode switch values, halt causes
// and the sequencer FSM state type.
package halt_pkg;

    localparam logic [1:0] MODE_RUN   = 2'b00;
    localparam logic [1:0] MODE_CYC   = 2'b01;
    localparam logic [1:0] MODE_INSTR = 2'b10;
    localparam logic [1:0] MODE_BURST = 2'b11;

    localparam logic [1:0] CAUSE_NONE = 2'b00;
    localparam logic [1:0] CAUSE_STEP = 2'b01;
    localparam logic [1:0] CAUSE_BP   = 2'b10;
    localparam logic [1:0] CAUSE_INIT = 2'b11;

    typedef enum logic [1:0] {
        ST_INIT   = 2'b00,
        ST_HALTED = 2'b01,
        ST_RUN    = 2'b10,
        ST_STEP   = 2'b11
    } state_e;

    // Index width that stays legal for a single breakpoint channel.
    function automatic int idx_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/halt_sequencer_panel_sync_debounce.sv
// Generic front-panel conditioner: SYNC_STAGES-deep synchroniser, debouncer that
// accepts a value after DEBOUNCE_CYC identical samples, and a rising-edge pulse.
module panel_sync_debounce #(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int W            = 1
) (
    input  logic         o_clk,
    input  logic         o_resetn,
    input  logic [W-1:0] async_i,
    output logic [W-1:0] stable_o,
    output logic [W-1:0] stable_nxt_o,
    output logic [W-1:0] rise_o
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYC + 1);

    logic [SYNC_STAGES-1:0][W-1:0] sync_q;
    logic [W-1:0]                  sync_s;
    logic [W-1:0]                  samp_q;
    logic [CNT_W-1:0]              run_q;
    logic [CNT_W-1:0]              run_d;
    logic [W-1:0]                  stable_q;
    logic [W-1:0]                  stable_d;
    logic [W-1:0]                  rise_q;
    logic [W-1:0]                  rise_d;

    assign sync_s = sync_q[SYNC_STAGES-1];

    // Run length counts how many consecutive identical synchronised samples were seen.
    always_comb begin
        run_d    = run_q;
        stable_d = stable_q;
        if (sync_s == samp_q) begin
            run_d = (run_q == CNT_W'(DEBOUNCE_CYC)) ? run_q : run_q + 1'b1;
        end else begin
            run_d = CNT_W'(1);
        end
        if ((run_d == CNT_W'(DEBOUNCE_CYC)) && (sync_s != stable_q)) begin
            stable_d = sync_s;
        end else begin
            stable_d = stable_q;
        end
        rise_d = stable_d & ~stable_q;
    end

    // Synchroniser chain and debounce state.
    always_ff @(posedge o_clk or negedge o_resetn) begin
        if (!o_resetn) begin
            sync_q   <= '0;
            samp_q   <= '0;
            run_q    <= '0;
            stable_q <= '0;
            rise_q   <= '0;
        end else begin
            sync_q   <= {sync_q[SYNC_STAGES-2:0], async_i};
            samp_q   <= sync_s;
            run_q    <= run_d;
            stable_q <= stable_d;
            rise_q   <= rise_d;
        end
    end

    assign stable_o     = stable_q;
    assign stable_nxt_o = stable_d;
    assign rise_o       = rise_q;

endmodule

// File: rtl/halt_sequencer.sv
// Single-step / halt sequencer feeding the CPU clock gate: conditions panel inputs,
// runs the free-run / cycle / instruction / burst step FSM and arbitrates breakpoints.
module halt_sequencer
    import halt_pkg::*;
#(
    parameter int SYNC_STAGES  = 2,
    parameter int DEBOUNCE_CYC = 4,
    parameter int N_BP         = 4,
    parameter int BURST_W      = 8
) (
    input  logic                       o_clk,
    input  logic                       o_resetn,
    input  logic                       i_btnStep,
    input  logic [1:0]                 i_swMode,
    input  logic [BURST_W-1:0]         i_burstCount,
    input  logic [N_BP-1:0]            i_bpHitN,
    input  logic [N_BP-1:0]            i_bpEnable,
    input  logic                       i_ctrlInstrFinishedN,
    output logic                       o_halt,
    output logic [1:0]                 o_haltCause,
    output logic [idx_width(N_BP)-1:0] o_bpIdx,
    output logic                       o_running
);

    localparam int IDX_W    = idx_width(N_BP);
    localparam int INIT_CYC = SYNC_STAGES + DEBOUNCE_CYC;
    localparam int INIT_W   = $clog2(INIT_CYC + 1);

    logic             press_s;
    logic             btn_stable_unused;
    logic             btn_nxt_unused;
    logic [1:0]       mode_s;
    logic [1:0]       mode_nxt_s;
    logic [1:0]       mode_rise_unused;
    logic [N_BP-1:0]  hit_vec_s;
    logic             bp_hit_s;
    logic [IDX_W-1:0] bp_low_s;
    logic             step_done_s;
    logic [BURST_W-1:0] burst_load_s;

    state_e             state_q;
    logic               halt_q;
    logic [1:0]         cause_q;
    logic [IDX_W-1:0]   bp_idx_q;
    logic               running_q;
    logic [1:0]         step_mode_q;
    logic [BURST_W-1:0] cnt_q;
    logic [INIT_W-1:0]  init_cnt_q;

    panel_sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .W            (1)
    ) u_btn (
        .o_clk        (o_clk),
        .o_resetn     (o_resetn),
        .async_i      (i_btnStep),
        .stable_o     (btn_stable_unused),
        .stable_nxt_o (btn_nxt_unused),
        .rise_o       (press_s)
    );

    panel_sync_debounce #(
        .SYNC_STAGES  (SYNC_STAGES),
        .DEBOUNCE_CYC (DEBOUNCE_CYC),
        .W            (2)
    ) u_mode (
        .o_clk        (o_clk),
        .o_resetn     (o_resetn),
        .async_i      (i_swMode),
        .stable_o     (mode_s),
        .stable_nxt_o (mode_nxt_s),
        .rise_o       (mode_rise_unused)
    );

    // Breakpoint arbitration: lowest enabled hitting channel wins.
    always_comb begin
        hit_vec_s = ~i_bpHitN & i_bpEnable;
        bp_hit_s  = |hit_vec_s;
        bp_low_s  = '0;
        for (int i = N_BP - 1; i >= 0; i--) begin
            bp_low_s = hit_vec_s[i] ? IDX_W'(i) : bp_low_s;
        end
    end

    // Completion condition of the step currently in progress.
    always_comb begin
        step_done_s  = 1'b1;
        burst_load_s = (i_burstCount == '0) ? BURST_W'(1) : i_burstCount;
        case (step_mode_q)
            MODE_CYC:   step_done_s = 1'b1;
            MODE_INSTR: step_done_s = ~i_ctrlInstrFinishedN;
            MODE_BURST: step_done_s = (cnt_q == BURST_W'(1));
            default:    step_done_s = 1'b1;
        endcase
    end

    // Sequencer FSM with registered halt, cause, index and running outputs.
    always_ff @(posedge o_clk or negedge o_resetn) begin
        if (!o_resetn) begin
            state_q     <= ST_INIT;
            halt_q      <= 1'b1;
            cause_q     <= CAUSE_INIT;
            bp_idx_q    <= '0;
            running_q   <= 1'b0;
            step_mode_q <= MODE_RUN;
            cnt_q       <= '0;
            init_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_INIT: begin
                    // The mode debouncer settles on this same edge, so use its next value.
                    if (init_cnt_q == INIT_W'(INIT_CYC - 1)) begin
                        if (mode_nxt_s == MODE_RUN) begin
                            state_q   <= ST_RUN;
                            halt_q    <= 1'b0;
                            running_q <= 1'b1;
                            cause_q   <= CAUSE_NONE;
                        end else begin
                            state_q   <= ST_HALTED;
                            cause_q   <= CAUSE_STEP;
                        end
                    end else begin
                        init_cnt_q <= init_cnt_q + 1'b1;
                    end
                end
                ST_HALTED: begin
                    if (press_s) begin
                        halt_q      <= 1'b0;
                        running_q   <= 1'b1;
                        cause_q     <= CAUSE_NONE;
                        bp_idx_q    <= '0;
                        step_mode_q <= mode_s;
                        cnt_q       <= burst_load_s;
                        state_q     <= (mode_s == MODE_RUN) ? ST_RUN : ST_STEP;
                    end
                end
                ST_RUN: begin
                    if (bp_hit_s) begin
                        state_q   <= ST_HALTED;
                        halt_q    <= 1'b1;
                        running_q <= 1'b0;
                        cause_q   <= CAUSE_BP;
                        bp_idx_q  <= bp_low_s;
                    end else if (mode_s != MODE_RUN) begin
                        state_q   <= ST_HALTED;
                        halt_q    <= 1'b1;
                        running_q <= 1'b0;
                        cause_q   <= CAUSE_STEP;
                    end
                end
                ST_STEP: begin
                    if (bp_hit_s || step_done_s) begin
                        state_q   <= ST_HALTED;
                        halt_q    <= 1'b1;
                        running_q <= 1'b0;
                        cause_q   <= bp_hit_s ? CAUSE_BP : CAUSE_STEP;
                        bp_idx_q  <= bp_hit_s ? bp_low_s : bp_idx_q;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                default: begin
                    state_q   <= ST_INIT;
                    halt_q    <= 1'b1;
                    running_q <= 1'b0;
                    cause_q   <= CAUSE_INIT;
                end
            endcase
        end
    end

    // A breakpoint stops the hitting instruction in the same cycle.
    assign o_halt      = halt_q | (bp_hit_s & running_q);
    assign o_haltCause = cause_q;
    assign o_bpIdx     = bp_idx_q;
    assign o_running   = running_q;

endmodule

// File: tb/tb_halt_sequencer.sv
// Self-checking bench for halt_sequencer: scenario tasks with randomized step lengths,
// burst counts and breakpoint patterns, expectations derived from the step rules.
module tb_halt_sequencer;
    import halt_pkg::*;

    localparam int SYNC = 2;
    localparam int DEB  = 4;
    localparam int NBP  = 4;
    localparam int BW   = 8;

    logic           clk    = 1'b0;
    logic           resetn = 1'b0;
    logic           btn    = 1'b0;
    logic [1:0]     mode   = 2'b00;
    logic [BW-1:0]  burst  = '0;
    logic [NBP-1:0] hitN   = '1;
    logic [NBP-1:0] en     = '0;
    logic           finN   = 1'b1;
    logic           halt;
    logic [1:0]     cause;
    logic [1:0]     idx;
    logic           running;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    halt_sequencer #(
        .SYNC_STAGES  (SYNC),
        .DEBOUNCE_CYC (DEB),
        .N_BP         (NBP),
        .BURST_W      (BW)
    ) dut (
        .o_clk                (clk),
        .o_resetn             (resetn),
        .i_btnStep            (btn),
        .i_swMode             (mode),
        .i_burstCount         (burst),
        .i_bpHitN             (hitN),
        .i_bpEnable           (en),
        .i_ctrlInstrFinishedN (finN),
        .o_halt               (halt),
        .o_haltCause          (cause),
        .o_bpIdx              (idx),
        .o_running            (running)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_mode(input logic [1:0] m);
        mode = m;
        repeat (SYNC + DEB + 3) tick();
    endtask

    function automatic int lowest(input logic [NBP-1:0] v);
        for (int i = 0; i < NBP; i++) begin
            if (v[i]) return i;
        end
        return 0;
    endfunction

    // Presses the button once and counts the cycles in which the CPU clock runs.
    task automatic press_window(input int bp_at, input logic [NBP-1:0] bp_vec, input int fin_at,
                                input logic [1:0] mode_mid, output int unh);
        logic h;
        unh = 0;
        btn = 1'b1;
        for (int c = 0; c < 60; c++) begin
            tick();
            h = halt;
            hitN = '1;
            finN = 1'b1;
            if (c == 10) btn = 1'b0;
            if (h === 1'b0) begin
                unh++;
                if (unh == 2) mode = mode_mid;
                if (unh == fin_at) finN = 1'b0;
                if (unh == bp_at) begin
                    hitN = ~bp_vec;
                    #1;
                    checks++;
                    if (halt !== 1'b1) begin
                        errors++;
                        $display("FAIL bp_same_cycle_step: o_halt=%0b expected 1", halt);
                    end
                end
            end
        end
    endtask

    task automatic test_reset();
        int n;
        resetn = 1'b0;
        mode = MODE_RUN;
        repeat (3) tick();
        checks++;
        if (halt !== 1'b1 || cause !== CAUSE_INIT || running !== 1'b0 || idx !== 2'd0) begin
            errors++;
            $display("FAIL reset_values: halt=%0b cause=%0b running=%0b idx=%0d expected 1/11/0/0",
                     halt, cause, running, idx);
        end
        resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (halt === 1'b1 && cause === CAUSE_INIT) n++;
            else break;
            tick();
        end
        checks++;
        if (n != SYNC + DEB) begin
            errors++;
            $display("FAIL init_length: %0d halted cycles, expected %0d", n, SYNC + DEB);
        end
        checks++;
        if (halt !== 1'b0 || running !== 1'b1 || cause !== CAUSE_NONE) begin
            errors++;
            $display("FAIL init_to_run: halt=%0b running=%0b cause=%0b expected 0/1/00", halt, running, cause);
        end
    endtask

    task automatic test_breakpoint();
        logic [NBP-1:0] hv;
        logic [NBP-1:0] dis;
        int exp_idx;
        for (int it = 0; it < 4; it++) begin
            if (it == 0) begin
                en = NBP'(4'b0100);
                hv = NBP'(4'b0100);
            end else begin
                en = NBP'($urandom_range(1, 15));
                hv = NBP'($urandom_range(0, 15));
                if ((hv & en) == '0) hv = hv | en;
            end
            exp_idx = lowest(hv & en);
            dis = ~en;
            if (dis != '0) begin
                hitN = ~dis;
                #1;
                checks++;
                if (halt !== 1'b0) begin
                    errors++;
                    $display("FAIL disabled_hit: o_halt=%0b expected 0 (en=%b)", halt, en);
                end
                tick();
                checks++;
                if (running !== 1'b1) begin
                    errors++;
                    $display("FAIL disabled_hit_run: running=%0b expected 1", running);
                end
                hitN = '1;
            end
            hitN = ~hv;
            #1;
            checks++;
            if (halt !== 1'b1) begin
                errors++;
                $display("FAIL bp_same_cycle_run: o_halt=%0b expected 1", halt);
            end
            tick();
            hitN = '1;
            checks++;
            if (cause !== CAUSE_BP || idx !== 2'(exp_idx) || running !== 1'b0) begin
                errors++;
                $display("FAIL bp_capture: cause=%0b idx=%0d running=%0b expected 10/%0d/0",
                         cause, idx, running, exp_idx);
            end
            btn = 1'b1;
            for (int k = 0; k < 30; k++) begin
                tick();
                if (running === 1'b1) break;
            end
            checks++;
            if (running !== 1'b1 || cause !== CAUSE_NONE || idx !== 2'd0) begin
                errors++;
                $display("FAIL bp_resume: running=%0b cause=%0b idx=%0d expected 1/00/0", running, cause, idx);
            end
            btn = 1'b0;
            repeat (12) tick();
        end
    endtask

    task automatic test_run_press_ignored();
        int unh;
        btn = 1'b1;
        repeat (12) tick();
        btn = 1'b0;
        repeat (12) tick();
        checks++;
        if (running !== 1'b1 || halt !== 1'b0) begin
            errors++;
            $display("FAIL run_press: running=%0b halt=%0b expected 1/0", running, halt);
        end
        set_mode(MODE_CYC);
        checks++;
        if (halt !== 1'b1 || cause !== CAUSE_STEP) begin
            errors++;
            $display("FAIL run_to_cyc: halt=%0b cause=%0b expected 1/01", halt, cause);
        end
        unh = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (halt === 1'b0) unh++;
        end
        checks++;
        if (unh != 0) begin
            errors++;
            $display("FAIL press_not_queued: %0d unhalted cycles, expected 0", unh);
        end
    endtask

    task automatic test_cycle_step();
        int unh;
        int total;
        int glen;
        logic [NBP-1:0] hv;
        total = 0;
        for (int p = 0; p < 3; p++) begin
            press_window(0, '0, 0, MODE_CYC, unh);
            total += unh;
            checks++;
            if (unh != 1 || cause !== CAUSE_STEP || halt !== 1'b1) begin
                errors++;
                $display("FAIL cyc_step%0d: unhalted=%0d cause=%0b expected 1/01", p, unh, cause);
            end
        end
        checks++;
        if (total != 3) begin
            errors++;
            $display("FAIL cyc_total: %0d unhalted cycles, expected 3", total);
        end
        glen = $urandom_range(1, DEB - 1);
        btn = 1'b1;
        repeat (glen) tick();
        btn = 1'b0;
        unh = 0;
        for (int k = 0; k < 30; k++) begin
            tick();
            if (halt === 1'b0) unh++;
        end
        checks++;
        if (unh != 0) begin
            errors++;
            $display("FAIL bounce_glitch: %0d unhalted cycles after %0d-cycle glitch, expected 0", unh, glen);
        end
        en = '1;
        hv = NBP'($urandom_range(1, 15));
        press_window(1, hv, 0, MODE_CYC, unh);
        checks++;
        if (unh != 1 || cause !== CAUSE_BP || idx !== 2'(lowest(hv))) begin
            errors++;
            $display("FAIL cyc_bp_priority: unhalted=%0d cause=%0b idx=%0d expected 1/10/%0d",
                     unh, cause, idx, lowest(hv));
        end
    endtask

    task automatic test_instr_step();
        int unh;
        int len;
        logic [1:0] mm;
        for (int it = 0; it < 3; it++) begin
            len = (it == 0) ? 5 : $urandom_range(1, 8);
            mm  = (it == 0) ? MODE_BURST : 2'($urandom_range(0, 3));
            set_mode(MODE_INSTR);
            press_window(0, '0, len, mm, unh);
            checks++;
            if (unh != len || cause !== CAUSE_STEP || halt !== 1'b1) begin
                errors++;
                $display("FAIL instr_step%0d: unhalted=%0d cause=%0b expected %0d/01", it, unh, cause, len);
            end
        end
    endtask

    task automatic test_burst();
        int unh;
        int n;
        int bp_at;
        int exp_unh;
        logic [NBP-1:0] hv;
        set_mode(MODE_BURST);
        en = '1;
        for (int it = 0; it < 6; it++) begin
            case (it)
                0: begin burst = BW'(7);  bp_at = 0; end
                1: begin burst = BW'(0);  bp_at = 0; end
                2: begin burst = BW'($urandom_range(1, 20)); bp_at = 0; end
                3: begin burst = BW'($urandom_range(1, 20)); bp_at = 0; end
                4: begin burst = BW'(7);  bp_at = 3; end
                default: begin burst = BW'(2); bp_at = 2; end
            endcase
            n = (burst == '0) ? 1 : int'(burst);
            hv = NBP'($urandom_range(1, 15));
            exp_unh = (bp_at != 0 && bp_at < n) ? bp_at : n;
            press_window(bp_at, hv, 0, MODE_BURST, unh);
            checks++;
            if (unh != exp_unh) begin
                errors++;
                $display("FAIL burst%0d_len: unhalted=%0d expected %0d (count=%0d)", it, unh, exp_unh, burst);
            end
            checks++;
            if (bp_at != 0) begin
                if (cause !== CAUSE_BP || idx !== 2'(lowest(hv))) begin
                    errors++;
                    $display("FAIL burst%0d_bp: cause=%0b idx=%0d expected 10/%0d", it, cause, idx, lowest(hv));
                end
            end else if (cause !== CAUSE_STEP) begin
                errors++;
                $display("FAIL burst%0d_cause: cause=%0b expected 01", it, cause);
            end
        end
    endtask

    task automatic test_reset_mid_burst();
        int n;
        int unh;
        burst = BW'(30);
        btn = 1'b1;
        n = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (halt === 1'b0) n++;
            if (n == 5) break;
        end
        checks++;
        if (n != 5) begin
            errors++;
            $display("FAIL burst_start_timeout: %0d unhalted cycles seen, expected 5", n);
        end
        resetn = 1'b0;
        btn = 1'b0;
        #1;
        checks++;
        if (halt !== 1'b1 || cause !== CAUSE_INIT || running !== 1'b0) begin
            errors++;
            $display("FAIL async_reset: halt=%0b cause=%0b running=%0b expected 1/11/0", halt, cause, running);
        end
        repeat (2) tick();
        resetn = 1'b1;
        n = 0;
        for (int k = 0; k < 50; k++) begin
            if (cause === CAUSE_INIT && halt === 1'b1) n++;
            else break;
            tick();
        end
        checks++;
        if (n != SYNC + DEB || cause !== CAUSE_STEP || halt !== 1'b1) begin
            errors++;
            $display("FAIL reinit: init cycles=%0d cause=%0b halt=%0b expected %0d/01/1", n, cause, halt, SYNC + DEB);
        end
        unh = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (halt === 1'b0) unh++;
        end
        checks++;
        if (unh != 0) begin
            errors++;
            $display("FAIL residual_count: %0d unhalted cycles after reset, expected 0", unh);
        end
        burst = BW'(3);
        press_window(0, '0, 0, MODE_BURST, unh);
        checks++;
        if (unh != 3 || cause !== CAUSE_STEP) begin
            errors++;
            $display("FAIL burst_after_reset: unhalted=%0d cause=%0b expected 3/01", unh, cause);
        end
    endtask

    initial begin
        test_reset();
        test_breakpoint();
        test_run_press_ignored();
        test_cycle_step();
        test_instr_step();
        test_burst();
        test_reset_mid_burst();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
